rip_trap_unit: RTL and testbench

Machine-mode trap and return engine for the RIP core. It is the consumer side of the trap contract fixed in rip_config: it owns the MTVEC, MEPC and MCAUSE registers and services CSR accesses from execute. On an exception (CAUSE_ILLEGAL_INST, CAUSE_ECALL, or an illegal CSR access) it records the trap and issues a redirect to the fetch stage through a valid/ready handshake. On mret it issues a redirect back to MEPC.

---
 rtl/rip_trap_unit.sv | 132 +++++++++++++
 tb/tb_rip_trap_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rip_trap_unit.sv
// rtl/rip_trap_unit.sv - machine-mode trap/return engine owning mtvec, mepc and mcause
// Traps and mret are turned into a held fetch redirect; CSR accesses from execute are serviced in IDLE.
module rip_trap_unit #(
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   RESET_MTVEC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 csr_valid,
    input  logic [1:0]           csr_op,
    input  logic [11:0]          csr_addr,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    input  logic                 exc_valid,
    input  logic [XLEN-1:0]      exc_cause,
    input  logic [XLEN-1:0]      exc_pc,
    input  logic                 mret_valid,
    output logic                 busy,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    input  logic                 redirect_ready
);

    localparam logic [11:0]     ADDR_MTVEC  = 12'h305;
    localparam logic [11:0]     ADDR_MEPC   = 12'h341;
    localparam logic [11:0]     ADDR_MCAUSE = 12'h342;

    localparam logic [1:0]      OP_READ = 2'b00;
    localparam logic [1:0]      OP_RW   = 2'b01;
    localparam logic [1:0]      OP_RS   = 2'b10;
    localparam logic [1:0]      OP_RC   = 2'b11;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL_INST = XLEN'(2);
    localparam logic [XLEN-1:0] ALIGN_MASK         = ~XLEN'(3);
    localparam logic [XLEN-1:0] MTVEC_INIT         = RESET_MTVEC & ALIGN_MASK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRAP = 2'd1,
        RET  = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;

    logic            addr_known;
    logic            in_idle;
    logic            illegal_csr;
    logic            trap_pending;
    logic            csr_write;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] csr_new;

    always_comb begin
        csr_rdata  = '0;
        addr_known = 1'b1;
        case (csr_addr)
            ADDR_MTVEC:  csr_rdata = mtvec;
            ADDR_MEPC:   csr_rdata = mepc;
            ADDR_MCAUSE: csr_rdata = mcause;
            default:     addr_known = 1'b0;
        endcase
    end

    // Priority: external exception > illegal CSR > mret > CSR write.
    assign in_idle      = (state == IDLE);
    assign illegal_csr  = in_idle && csr_valid && !addr_known;
    assign trap_pending = in_idle && (exc_valid || illegal_csr);
    assign trap_cause   = exc_valid ? exc_cause : CAUSE_ILLEGAL_INST;
    assign csr_write    = in_idle && csr_valid && addr_known && (csr_op != OP_READ)
                          && !exc_valid && !mret_valid;

    always_comb begin
        csr_new = csr_rdata;
        case (csr_op)
            OP_RW:   csr_new = csr_wdata;
            OP_RS:   csr_new = csr_rdata | csr_wdata;
            OP_RC:   csr_new = csr_rdata & ~csr_wdata;
            default: csr_new = csr_rdata;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mtvec          <= MTVEC_INIT;
            mepc           <= '0;
            mcause         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_pending) begin
                        // Target is the pre-write mtvec; any same-cycle CSR write is dropped.
                        mepc           <= exc_pc & ALIGN_MASK;
                        mcause         <= trap_cause;
                        redirect_pc    <= mtvec;
                        redirect_valid <= 1'b1;
                        state          <= TRAP;
                    end else if (mret_valid) begin
                        redirect_pc    <= mepc;
                        redirect_valid <= 1'b1;
                        state          <= RET;
                    end else if (csr_write) begin
                        case (csr_addr)
                            ADDR_MTVEC:  mtvec  <= csr_new & ALIGN_MASK;
                            ADDR_MEPC:   mepc   <= csr_new & ALIGN_MASK;
                            ADDR_MCAUSE: mcause <= csr_new;
                            default:     mcause <= mcause;
                        endcase
                    end
                end
                TRAP, RET: begin
                    if (redirect_valid && redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    redirect_valid <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rip_trap_unit.sv
// tb/tb_rip_trap_unit.sv - directed bench for rip_trap_unit with a redirect-target scoreboard
module tb_rip_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    rip_trap_unit #(
        .XLEN        (32),
        .RESET_MTVEC (32'h0000_0103)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_valid      (csr_valid),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .mret_valid     (mret_valid),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        csr_valid  = 1'b0;
        csr_op     = 2'b00;
        csr_wdata  = '0;
        exc_valid  = 1'b0;
        exc_cause  = '0;
        mret_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic csr_access(input string tag, input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [31:0] old_exp);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wdata;
        #1;
        check(tag, csr_rdata, old_exp);
        step();
        idle_inputs();
    endtask

    // Wait for a redirect, then pop the expected target from the scoreboard.
    task automatic expect_redirect(input string tag);
        logic [31:0] exp;
        int          n;
        n = 0;
        while (!redirect_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {31'b0, redirect_valid}, 32'd1);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            exp = sb.pop_front();
            check({tag, "_pc"}, redirect_pc, exp);
        end
    endtask

    task automatic handshake(input string tag);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check({tag, "_rv_low"}, {31'b0, redirect_valid}, 32'd0);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_ready = 1'b0;
        csr_addr       = '0;
        exc_pc         = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        rd("rst_mtvec", 12'h305, 32'h0000_0100);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rv", {31'b0, redirect_valid}, 32'd0);
        check("rst_rpc", redirect_pc, 32'h0);

        csr_access("rw_old", 2'b01, 12'h305, 32'h8000_0042, 32'h0000_0100);
        rd("rw_new", 12'h305, 32'h8000_0040);
        csr_access("rs_old", 2'b10, 12'h305, 32'h0000_0001, 32'h8000_0040);
        rd("rs_new", 12'h305, 32'h8000_0040);
        csr_access("rc_old", 2'b11, 12'h305, 32'h8000_0000, 32'h8000_0040);
        rd("rc_new", 12'h305, 32'h0000_0040);
        csr_access("ro_old", 2'b00, 12'h342, 32'hFFFF_FFFF, 32'h0);
        rd("ro_new", 12'h342, 32'h0);

        exc_valid = 1'b1;
        exc_cause = 32'd11;
        exc_pc    = 32'h0000_1234;
        sb.push_back(32'h0000_0040);
        step();
        idle_inputs();
        expect_redirect("ecall");
        rd("ecall_mepc", 12'h341, 32'h0000_1234);
        rd("ecall_mcause", 12'h342, 32'd11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ecall_hold_rv", {31'b0, redirect_valid}, 32'd1);
            check("ecall_hold_pc", redirect_pc, 32'h0000_0040);
        end
        handshake("ecall");

        csr_valid = 1'b1;
        csr_op    = 2'b01;
        csr_addr  = 12'h7C0;
        csr_wdata = 32'hFFFF_FFFF;
        exc_pc    = 32'h0000_0200;
        #1;
        check("ill_rdata", csr_rdata, 32'h0);
        sb.push_back(32'h0000_0040);
        step();
        idle_inputs();
        expect_redirect("ill");
        rd("ill_mcause", 12'h342, 32'd2);
        rd("ill_mepc", 12'h341, 32'h0000_0200);
        rd("ill_mtvec", 12'h305, 32'h0000_0040);
        handshake("ill");

        exc_valid  = 1'b1;
        exc_cause  = 32'd11;
        exc_pc     = 32'h0000_0202;
        mret_valid = 1'b1;
        csr_valid  = 1'b1;
        csr_op     = 2'b01;
        csr_addr   = 12'h341;
        csr_wdata  = 32'h0000_5550;
        sb.push_back(32'h0000_0040);
        step();
        idle_inputs();
        expect_redirect("prio");
        rd("prio_mepc", 12'h341, 32'h0000_0200);
        rd("prio_mcause", 12'h342, 32'd11);
        exc_valid  = 1'b1;
        exc_cause  = 32'd5;
        exc_pc     = 32'h0000_0999;
        mret_valid = 1'b1;
        step();
        idle_inputs();
        rd("nested_mcause", 12'h342, 32'd11);
        rd("nested_mepc", 12'h341, 32'h0000_0200);
        check("nested_pc", redirect_pc, 32'h0000_0040);
        handshake("prio");

        mret_valid = 1'b1;
        sb.push_back(32'h0000_0200);
        step();
        idle_inputs();
        expect_redirect("mret");
        handshake("mret");

        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check("stray_ready_rv", {31'b0, redirect_valid}, 32'd0);

        exc_valid = 1'b1;
        exc_cause = 32'd2;
        exc_pc    = 32'h0000_0400;
        sb.push_back(32'h0000_0040);
        step();
        idle_inputs();
        expect_redirect("pre_rst");
        #2 rst = 1'b1;
        #1;
        check("async_rv", {31'b0, redirect_valid}, 32'd0);
        check("async_busy", {31'b0, busy}, 32'd0);
        step();
        rst = 1'b0;
        step();
        rd("post_mtvec", 12'h305, 32'h0000_0100);
        rd("post_mepc", 12'h341, 32'h0);
        rd("post_mcause", 12'h342, 32'h0);
        check("post_rpc", redirect_pc, 32'h0);
        check("post_busy", {31'b0, busy}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
